// File: rtl/barrel_shift_arbiter.sv
// Round-robin arbiter sharing one combinational 32-bit barrel shifter among NREQ
// valid/ready requesters, with a registered single-entry response. BSA_PERF_EN adds perf counters.
module barrel_shift_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*32-1:0]   req_d,
    input  logic [NREQ*5-1:0]    req_amt,
    input  logic [NREQ*2-1:0]    req_op,
    input  logic [NREQ-1:0]      req_dir,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_q,
    output logic [IDW-1:0]       rsp_id
`ifdef BSA_PERF_EN
    ,
    input  logic                 perf_clr,
    output logic [31:0]          perf_ops,
    output logic [15:0]          perf_stall
`endif
);

    // Handshake: a requester transfers on the clock edge where req_valid[i] && req_ready[i];
    // the response transfers on the edge where rsp_valid && rsp_ready.
    typedef enum logic {EMPTY, FULL} state_t;

    state_t         state;
    state_t         state_next;
    logic [IDW-1:0] rr_ptr;
    logic           can_accept;
    logic           grant;
    logic [IDW-1:0] grant_idx;
    int             idx;
    int             gi;
    logic [31:0]    sel_d;
    logic [4:0]     sel_amt;
    logic [1:0]     sel_op;
    logic           sel_dir;
    logic [5:0]     inv_amt;
    logic [31:0]    shift_q;

    assign rsp_valid  = (state == FULL);
    assign can_accept = !rsp_valid || rsp_ready;

    // Search starts at rr_ptr and wraps, so the most recent winner is tried last.
    always_comb begin
        req_ready = '0;
        grant     = 1'b0;
        grant_idx = '0;
        idx       = 0;
        if (can_accept) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = int'(rr_ptr) + k;
                if (idx >= NREQ) idx = idx - NREQ;
                if (!grant && req_valid[idx]) begin
                    grant     = 1'b1;
                    grant_idx = IDW'(idx);
                end
            end
        end
        if (grant) req_ready[grant_idx] = 1'b1;
    end

    assign gi      = int'(grant_idx);
    assign sel_d   = req_d[32*gi +: 32];
    assign sel_amt = req_amt[5*gi +: 5];
    assign sel_op  = req_op[2*gi +: 2];
    assign sel_dir = req_dir[gi];
    // A 32-bit shift by 32 yields zero, so amt=0 rotates return d unchanged.
    assign inv_amt = 6'd32 - {1'b0, sel_amt};

    always_comb begin
        shift_q = sel_d;
        case (sel_op)
            2'b00: shift_q = sel_d << sel_amt;
            2'b01: shift_q = sel_d >> sel_amt;
            2'b10: shift_q = $unsigned($signed(sel_d) >>> sel_amt);
            default: begin
                if (sel_dir) shift_q = (sel_d >> sel_amt) | (sel_d << inv_amt);
                else         shift_q = (sel_d << sel_amt) | (sel_d >> inv_amt);
            end
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY: if (grant) state_next = FULL;
            FULL:  if (rsp_ready && !grant) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= EMPTY;
            rr_ptr <= '0;
            rsp_q  <= '0;
            rsp_id <= '0;
        end else begin
            state <= state_next;
            if (grant) begin
                rsp_q  <= shift_q;
                rsp_id <= grant_idx;
                rr_ptr <= (gi == NREQ - 1) ? '0 : grant_idx + 1'b1;
            end
        end
    end

`ifdef BSA_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_ops   <= '0;
            perf_stall <= '0;
        end else if (perf_clr) begin
            perf_ops   <= '0;
            perf_stall <= '0;
        end else begin
            if (grant) perf_ops <= perf_ops + 32'd1;
            if (rsp_valid && !rsp_ready && perf_stall != 16'hFFFF)
                perf_stall <= perf_stall + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_barrel_shift_arbiter.sv
// Directed bench for barrel_shift_arbiter: reset, shifter ops, round-robin, backpressure,
// fairness and (with BSA_PERF_EN) the performance counters.
module tb_barrel_shift_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                clk;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*32-1:0]  req_d;
    logic [NREQ*5-1:0]   req_amt;
    logic [NREQ*2-1:0]   req_op;
    logic [NREQ-1:0]     req_dir;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [31:0]         rsp_q;
    logic [IDW-1:0]      rsp_id;
`ifdef BSA_PERF_EN
    logic                perf_clr;
    logic [31:0]         perf_ops;
    logic [15:0]         perf_stall;
`endif

    int total = 0;
    int bad   = 0;

    barrel_shift_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_d     (req_d),
        .req_amt   (req_amt),
        .req_op    (req_op),
        .req_dir   (req_dir),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_q     (rsp_q),
        .rsp_id    (rsp_id)
`ifdef BSA_PERF_EN
        ,
        .perf_clr  (perf_clr),
        .perf_ops  (perf_ops),
        .perf_stall(perf_stall)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int i, input logic [31:0] d, input logic [4:0] amt,
                           input logic [1:0] op, input logic dir);
        req_d[32*i +: 32] = d;
        req_amt[5*i +: 5] = amt;
        req_op[2*i +: 2]  = op;
        req_dir[i]        = dir;
        req_valid[i]      = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", rsp_valid); end
        total++; if (rsp_q !== 32'h0) begin bad++; $display("FAIL reset_q got=%h exp=0", rsp_q); end
        total++; if (rsp_id !== 2'd0) begin bad++; $display("FAIL reset_id got=%0d exp=0", rsp_id); end
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
`ifdef BSA_PERF_EN
        total++; if (perf_ops !== 32'd0 || perf_stall !== 16'd0) begin bad++; $display("FAIL reset_perf got=%0d/%0d exp=0/0", perf_ops, perf_stall); end
`endif
        rst_n = 1'b1;
        tick();
        // Pending response from req1 (moves rr_ptr to 2), then reset while it waits.
        set_req(1, 32'h1234_5678, 5'd0, 2'b00, 1'b0);
        #1;
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL pre_reset_grant got=%b exp=0010", req_ready); end
        tick();
        req_valid = '0;
        #1;
        total++; if (rsp_valid !== 1'b1 || rsp_q !== 32'h1234_5678) begin bad++; $display("FAIL pre_reset_rsp got=%b/%h exp=1/12345678", rsp_valid, rsp_q); end
        rst_n = 1'b0;
        #1;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL midreset_valid got=%b exp=0", rsp_valid); end
        total++; if (rsp_q !== 32'h0) begin bad++; $display("FAIL midreset_q got=%h exp=0", rsp_q); end
        total++; if (rsp_id !== 2'd0) begin bad++; $display("FAIL midreset_id got=%0d exp=0", rsp_id); end
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL midreset_ready got=%b exp=0000", req_ready); end
        #3;
        rst_n = 1'b1;
        tick();
        req_valid = 4'b0101;
        #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL post_reset_first got=%b exp=0001", req_ready); end
        req_valid = '0;
    endtask

    task automatic test_single_ops();
        logic [1:0]  t_op  [6];
        logic        t_dir [6];
        logic [4:0]  t_amt [6];
        logic [31:0] t_exp [6];
        t_op  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        t_dir = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        t_amt = '{5'd4, 5'd4, 5'd4, 5'd4, 5'd4, 5'd0};
        t_exp = '{32'h0000_0010, 32'h0800_0000, 32'hF800_0000,
                  32'h0000_0018, 32'h1800_0000, 32'h8000_0001};
        rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            set_req(1, 32'h8000_0001, t_amt[k], t_op[k], t_dir[k]);
            #1;
            total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL op%0d_ready got=%b exp=0010", k, req_ready); end
            tick();
            req_valid = '0;
            #1;
            total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL op%0d_latency got=%b exp=1", k, rsp_valid); end
            total++; if (rsp_q !== t_exp[k]) begin bad++; $display("FAIL op%0d_q got=%h exp=%h", k, rsp_q, t_exp[k]); end
            total++; if (rsp_id !== 2'd1) begin bad++; $display("FAIL op%0d_id got=%0d exp=1", k, rsp_id); end
            tick();
            total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL op%0d_drain got=%b exp=0", k, rsp_valid); end
        end
    endtask

    task automatic test_round_robin();
        int exp_i;
        rsp_ready = 1'b1;
        // Grant req3 alone so the pointer wraps back to 0.
        set_req(3, 32'h0, 5'd0, 2'b00, 1'b0);
        tick();
        req_valid = '0;
        tick();
        for (int i = 0; i < NREQ; i++) set_req(i, 32'hA0 + i, 5'd0, 2'b00, 1'b0);
        for (int k = 0; k < 8; k++) begin
            exp_i = k % NREQ;
            #1;
            total++; if (req_ready !== 4'(1 << exp_i)) begin bad++; $display("FAIL rr%0d_ready got=%b exp_idx=%0d", k, req_ready, exp_i); end
            tick();
            total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(exp_i) || rsp_q !== 32'hA0 + exp_i) begin
                bad++; $display("FAIL rr%0d_rsp got=%b/%0d/%h exp=1/%0d/%h", k, rsp_valid, rsp_id, rsp_q, exp_i, 32'hA0 + exp_i);
            end
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        set_req(0, 32'h0000_0011, 5'd1, 2'b00, 1'b0);
        set_req(2, 32'h0000_00F0, 5'd4, 2'b01, 1'b0);
        #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL bp_first got=%b exp=0001", req_ready); end
        tick();
        for (int k = 0; k < 5; k++) begin
            #1;
            total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL bp%0d_ready got=%b exp=0000", k, req_ready); end
            total++; if (rsp_valid !== 1'b1 || rsp_q !== 32'h22 || rsp_id !== 2'd0) begin
                bad++; $display("FAIL bp%0d_hold got=%b/%h/%0d exp=1/00000022/0", k, rsp_valid, rsp_q, rsp_id);
            end
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL bp_release_ready got=%b exp=0100", req_ready); end
        tick();
        req_valid = '0;
        total++; if (rsp_valid !== 1'b1 || rsp_q !== 32'h0F || rsp_id !== 2'd2) begin
            bad++; $display("FAIL bp_release_rsp got=%b/%h/%0d exp=1/0000000f/2", rsp_valid, rsp_q, rsp_id);
        end
        tick();
    endtask

    task automatic test_fairness();
        int exp_i;
        rsp_ready = 1'b1;
        set_req(2, 32'h2, 5'd0, 2'b00, 1'b0);
        #1;
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL fair_prime got=%b exp=0100", req_ready); end
        tick();
        set_req(0, 32'h0, 5'd0, 2'b00, 1'b0);
        for (int k = 0; k < 4; k++) begin
            exp_i = (k % 2 == 0) ? 0 : 2;
            #1;
            total++; if (req_ready !== 4'(1 << exp_i)) begin bad++; $display("FAIL fair%0d_ready got=%b exp_idx=%0d", k, req_ready, exp_i); end
            tick();
            total++; if (rsp_id !== 2'(exp_i)) begin bad++; $display("FAIL fair%0d_id got=%0d exp=%0d", k, rsp_id, exp_i); end
        end
        req_valid = '0;
        tick();
    endtask

`ifdef BSA_PERF_EN
    task automatic test_perf();
        perf_clr = 1'b1;
        tick();
        perf_clr = 1'b0;
        total++; if (perf_ops !== 32'd0 || perf_stall !== 16'd0) begin bad++; $display("FAIL perf_clr0 got=%0d/%0d exp=0/0", perf_ops, perf_stall); end
        rsp_ready = 1'b1;
        set_req(1, 32'h5, 5'd1, 2'b00, 1'b0);
        repeat (10) tick();
        req_valid = '0;
        rsp_ready = 1'b0;
        repeat (3) tick();
        total++; if (perf_ops !== 32'd10) begin bad++; $display("FAIL perf_ops got=%0d exp=10", perf_ops); end
        total++; if (perf_stall !== 16'd3) begin bad++; $display("FAIL perf_stall got=%0d exp=3", perf_stall); end
        perf_clr = 1'b1;
        tick();
        perf_clr = 1'b0;
        total++; if (perf_ops !== 32'd0 || perf_stall !== 16'd0) begin bad++; $display("FAIL perf_clr got=%0d/%0d exp=0/0", perf_ops, perf_stall); end
        repeat (70000) tick();
        total++; if (perf_stall !== 16'hFFFF) begin bad++; $display("FAIL perf_sat got=%h exp=ffff", perf_stall); end
        rsp_ready = 1'b1;
        tick();
    endtask
`endif

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_d     = '0;
        req_amt   = '0;
        req_op    = '0;
        req_dir   = '0;
        rsp_ready = 1'b0;
`ifdef BSA_PERF_EN
        perf_clr  = 1'b0;
`endif
        test_reset();
        test_single_ops();
        test_round_robin();
        test_backpressure();
        test_fairness();
`ifdef BSA_PERF_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
